// File: rtl/booth_seq_ctrl.sv
// Radix-2 Booth sequential multiplier controller: one add/sub + arithmetic shift
// per cycle over A/Q/M registers, and drives the XOR complementer and carry-in.
module booth_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic                 dp_inv,
  output logic                 dp_cin
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_next;
  logic [WIDTH:0]   a;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] m;
  logic             q_m1;
  logic [CW-1:0]    cnt;

  logic             accept, last, add_en;
  logic [WIDTH:0]   m_ext, addend, a_sum, a_shift;
  logic [WIDTH-1:0] q_shift;

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_next = RUN;
        accept     = 1'b1;
      end
      RUN: if (cnt == '0) begin
        state_next = IDLE;
        last       = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy   = (state == RUN);
  assign dp_inv = busy && q[0] && !q_m1;
  assign dp_cin = dp_inv;

  // Subtraction reuses the adder: XOR M with all-ones and inject carry-in 1.
  always_comb begin
    m_ext   = {m[WIDTH-1], m};
    addend  = m_ext ^ {(WIDTH+1){dp_inv}};
    add_en  = q[0] ^ q_m1;
    a_sum   = add_en ? (a + addend + {{WIDTH{1'b0}}, dp_cin}) : a;
    a_shift = {a_sum[WIDTH], a_sum[WIDTH:1]};
    q_shift = {a_sum[0], q[WIDTH-1:1]};
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed above.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      done    <= 1'b0;
      product <= '0;
      a       <= '0;
      q       <= '0;
      q_m1    <= 1'b0;
      m       <= '0;
      cnt     <= '0;
    end else begin
      state <= state_next;
      done  <= last;
      if (accept) begin
        a    <= '0;
        q    <= multiplier;
        q_m1 <= 1'b0;
        m    <= multiplicand;
        cnt  <= CNT_INIT;
      end else if (busy) begin
        a    <= a_shift;
        q    <= q_shift;
        q_m1 <= q[0];
        cnt  <= cnt - CNT_ONE;
      end
      if (last) begin
        product <= {a_shift[WIDTH-1:0], q_shift};
      end
    end
  end

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Self-checking bench for booth_seq_ctrl: table of operand/product vectors,
// scoreboard queue of expected products, and multi-cycle corner sequences.
module tb_booth_seq_ctrl;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;
  logic           dp_inv;
  logic           dp_cin;

  booth_seq_ctrl #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product),
    .dp_inv       (dp_inv),
    .dp_cin       (dp_cin)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   m;
    logic [W-1:0]   q;
    logic [2*W-1:0] p;
  } vec_t;

  vec_t           vecs[8];
  logic [2*W-1:0] sb[$];
  logic [2*W-1:0] last_prod;
  int             total = 0;
  int             bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Number of subtract iterations: multiplier bit 1 preceded by a 0 (bit -1 = 0).
  function automatic int count_inv(input logic [W-1:0] q);
    int n = 0;
    logic prev = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (q[i] && !prev) n++;
      prev = q[i];
    end
    return n;
  endfunction

  // Issues one operation and returns on the negedge where done is observed.
  task automatic run_op(input logic [W-1:0] m, input logic [W-1:0] q,
                        input logic [2*W-1:0] exp, input bit repulse);
    int busy_cnt = 0;
    int inv_cnt  = 0;
    int cin_bad  = 0;
    int guard    = 0;
    logic [2*W-1:0] want;
    @(negedge clk);
    multiplicand = m;
    multiplier   = q;
    start        = 1'b1;
    sb.push_back(exp);
    @(negedge clk);
    start = 1'b0;
    check("product_held_in_run", 32'(product), 32'(last_prod));
    while (!done && guard < 200) begin
      if (busy) busy_cnt++;
      if (dp_inv) inv_cnt++;
      if (dp_cin !== dp_inv) cin_bad++;
      if (repulse && guard == 2) begin
        start        = 1'b1;
        multiplicand = ~m;
        multiplier   = q + 8'd3;
      end else if (repulse && guard == 3) begin
        start = 1'b0;
      end
      @(negedge clk);
      guard++;
    end
    check("done_seen", 32'(done), 32'(1));
    check("busy_cycles", 32'(busy_cnt), 32'(W));
    check("busy_low_at_done", 32'(busy), 32'(0));
    check("dp_inv_pulses", 32'(inv_cnt), 32'(count_inv(q)));
    check("dp_cin_eq_inv", 32'(cin_bad), 32'(0));
    if (sb.size() > 0) begin
      want = sb.pop_front();
      check("product", 32'(product), 32'(want));
      last_prod = want;
    end
  endtask

  initial begin
    logic signed [W-1:0]   rm, rq;
    logic signed [2*W-1:0] rp;
    int gap;
    bit seen;

    vecs[0] = '{m: 8'd3,   q: 8'd5,   p: 16'd15};
    vecs[1] = '{m: 8'h80,  q: 8'h80,  p: 16'h4000};
    vecs[2] = '{m: 8'h80,  q: 8'h7F,  p: 16'hC080};
    vecs[3] = '{m: 8'h7F,  q: 8'hFF,  p: 16'hFF81};
    vecs[4] = '{m: 8'h55,  q: 8'h00,  p: 16'h0000};
    vecs[5] = '{m: 8'h55,  q: 8'hAA,  p: 16'hE372};
    vecs[6] = '{m: 8'hFF,  q: 8'hFF,  p: 16'h0001};
    vecs[7] = '{m: 8'h01,  q: 8'h80,  p: 16'hFF80};

    rst = 1'b1;
    start = 1'b0;
    multiplicand = '0;
    multiplier = '0;
    last_prod = '0;
    repeat (3) @(negedge clk);
    check("reset_busy",    32'(busy),    32'(0));
    check("reset_done",    32'(done),    32'(0));
    check("reset_product", 32'(product), 32'(0));
    check("reset_dp_inv",  32'(dp_inv),  32'(0));
    check("reset_dp_cin",  32'(dp_cin),  32'(0));
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].m, vecs[i].q, vecs[i].p, 1'b0);
      @(negedge clk);
      check("done_one_cycle", 32'(done), 32'(0));
    end

    for (int i = 0; i < 4; i++) begin
      rm = W'($urandom);
      rq = W'($urandom);
      rp = rm * rq;
      run_op(rm, rq, rp, 1'b0);
      @(negedge clk);
      check("done_one_cycle_rand", 32'(done), 32'(0));
    end

    // Start re-pulsed with different operands mid-run must be ignored.
    run_op(8'h07, 8'hFD, 16'hFFEB, 1'b1);
    @(negedge clk);
    check("repulse_no_extra_op", 32'(busy), 32'(0));

    // Reset in the middle of a run aborts it.
    @(negedge clk);
    multiplicand = 8'd5;
    multiplier   = 8'd9;
    start        = 1'b1;
    sb.push_back(16'd45);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy",    32'(busy),    32'(0));
    check("abort_done",    32'(done),    32'(0));
    check("abort_product", 32'(product), 32'(0));
    check("abort_dp_inv",  32'(dp_inv),  32'(0));
    sb.delete();
    last_prod = '0;
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (W + 3) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("abort_no_done", 32'(seen), 32'(0));

    // Back-to-back: start asserted in the done cycle is accepted at once.
    run_op(8'hF9, 8'h06, 16'hFFD6, 1'b0);
    multiplicand = 8'hF6;
    multiplier   = 8'h0C;
    start        = 1'b1;
    sb.push_back(16'hFF88);
    @(negedge clk);
    start = 1'b0;
    check("b2b_done_one_cycle", 32'(done), 32'(0));
    check("b2b_busy_immediate", 32'(busy), 32'(1));
    gap = 1;
    while (!done && gap < 200) begin
      @(negedge clk);
      gap++;
    end
    check("b2b_gap", 32'(gap), 32'(W + 1));
    if (sb.size() > 0) check("b2b_product", 32'(product), 32'(sb.pop_front()));
    @(negedge clk);
    check("b2b_done_clear", 32'(done), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
